datapath_router_mc: RTL and testbench

- Multi-channel successor to the single-datapath router.
- Accepts instruction requests from PORTS requester threads and dispatches them round-robin across DPS identical datapath units.
- Tracks which port owns each in-flight datapath and writes each result back to its originating port.
- Sits between the per-thread network evaluators and the pool of shared arithmetic datapaths.

---
 rtl/datapath_router_mc_if.sv | 29 ++
 rtl/datapath_router_mc.sv | 158 +++++++++++++++
 tb/tb_datapath_router_mc.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/datapath_router_mc_if.sv
// Bundle for the router's requester-port side and datapath-pool side.
// The router takes the slave modport. The requesters and datapaths, or a bench, take the master modport.
interface datapath_router_mc_if #(
  parameter int PORTS    = 4,
  parameter int DPS      = 2,
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 32
);
  logic [INSTR_W*PORTS-1:0]  instruction;
  logic [PORTS-1:0]          start;
  logic [RESULT_W*PORTS-1:0] result;
  logic [PORTS-1:0]          finished;
  logic [PORTS-1:0]          overrun;
  logic [INSTR_W*DPS-1:0]    instruction_dp;
  logic [DPS-1:0]            start_dp;
  logic [RESULT_W*DPS-1:0]   result_dp;
  logic [DPS-1:0]            finished_dp;
  logic [DPS-1:0]            busy_dp;

  modport master (
    output instruction, start, result_dp, finished_dp,
    input  result, finished, overrun, instruction_dp, start_dp, busy_dp
  );

  modport slave (
    input  instruction, start, result_dp, finished_dp,
    output result, finished, overrun, instruction_dp, start_dp, busy_dp
  );
endinterface

// File: rtl/datapath_router_mc.sv
// Round-robin router from PORTS requester threads onto DPS shared datapaths.
// It records which port owns each datapath so that every result returns to the port that issued it.
module datapath_router_mc #(
  parameter int PORTS    = 4,
  parameter int DPS      = 2,
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 32
) (
  input  logic                clock,
  input  logic                resetn,
  datapath_router_mc_if.slave bus
);
  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int DP_W  = (DPS > 1) ? $clog2(DPS) : 1;

  typedef enum logic [1:0] {
    P_IDLE,
    P_PENDING,
    P_INFLIGHT
  } port_state_e;

  port_state_e         state_q [PORTS];
  port_state_e         state_d [PORTS];
  logic [INSTR_W-1:0]  buf_q   [PORTS];
  logic [RESULT_W-1:0] res_q   [PORTS];
  logic [RESULT_W-1:0] res_d   [PORTS];
  logic [INSTR_W-1:0]  idp_q   [DPS];
  logic [INSTR_W-1:0]  idp_d   [DPS];
  logic [PTR_W-1:0]    owner_q [DPS];
  logic [PTR_W-1:0]    owner_d [DPS];

  logic [PORTS-1:0] ovr_q, ovr_d;
  logic [PORTS-1:0] accept, pending;
  logic [DPS-1:0]   sdp_q, sdp_d;
  logic [DPS-1:0]   busy_q, busy_d;
  logic [DPS-1:0]   complete;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] grant_port;
  logic [DP_W-1:0]  grant_dp;
  logic             port_found, dp_found, dispatch;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign pending[p]                            = (state_q[p] == P_PENDING);
    assign accept[p]                             = bus.start[p] && (state_q[p] == P_IDLE);
    assign bus.finished[p]                       = (state_q[p] == P_IDLE);
    assign bus.result[p*RESULT_W +: RESULT_W]    = res_q[p];
  end

  // A datapath's completion pulse counts only while it is owned and outside its dispatch cycle.
  for (genvar d = 0; d < DPS; d++) begin : g_dp
    assign bus.instruction_dp[d*INSTR_W +: INSTR_W] = idp_q[d];
    assign complete[d] = bus.finished_dp[d] & busy_q[d] & ~sdp_q[d];
  end

  assign bus.overrun  = ovr_q;
  assign bus.start_dp = sdp_q;
  assign bus.busy_dp  = busy_q;
  assign dispatch     = port_found & dp_found;

  // Grant the first pending port at or after rr_q, wrapping around the port range.
  always_comb begin
    int idx;
    port_found = 1'b0;
    grant_port = '0;
    idx        = 0;
    for (int i = 0; i < PORTS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= PORTS) idx -= PORTS;
      if (!port_found && pending[PTR_W'(idx)]) begin
        port_found = 1'b1;
        grant_port = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    dp_found = 1'b0;
    grant_dp = '0;
    for (int d = DPS - 1; d >= 0; d--) begin
      if (!busy_q[d]) begin
        dp_found = 1'b1;
        grant_dp = DP_W'(d);
      end
    end
  end

  // NOTE: every signal written here gets a default first. Without those defaults the
  // block would infer latches. Blocking '=' is correct inside combinational logic.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    idp_d   = idp_q;
    owner_d = owner_q;
    ovr_d   = ovr_q;
    busy_d  = busy_q;
    sdp_d   = '0;
    rr_d    = rr_q;

    for (int p = 0; p < PORTS; p++) begin
      if (bus.start[p]) begin
        if (state_q[p] == P_IDLE) state_d[p] = P_PENDING;
        else                      ovr_d[p]   = 1'b1;
      end
    end

    // Owners are distinct, so simultaneous completions never collide on a port.
    for (int d = 0; d < DPS; d++) begin
      if (complete[d]) begin
        res_d[owner_q[d]]   = bus.result_dp[d*RESULT_W +: RESULT_W];
        state_d[owner_q[d]] = P_IDLE;
        busy_d[d]           = 1'b0;
      end
    end

    if (dispatch) begin
      sdp_d[grant_dp]      = 1'b1;
      busy_d[grant_dp]     = 1'b1;
      idp_d[grant_dp]      = buf_q[grant_port];
      owner_d[grant_dp]    = grant_port;
      state_d[grant_port]  = P_INFLIGHT;
      rr_d = (grant_port == PTR_W'(PORTS - 1)) ? '0 : grant_port + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together on the edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < PORTS; p++) begin
        state_q[p] <= P_IDLE;
        res_q[p]   <= '0;
      end
      for (int d = 0; d < DPS; d++) begin
        idp_q[d]   <= '0;
        owner_q[d] <= '0;
      end
      ovr_q  <= '0;
      sdp_q  <= '0;
      busy_q <= '0;
      rr_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idp_q   <= idp_d;
      owner_q <= owner_d;
      ovr_q   <= ovr_d;
      sdp_q   <= sdp_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
    end
  end

  // NOTE: the request buffers have no reset. A buffer is read only after an accept has written it.
  always_ff @(posedge clock) begin
    for (int p = 0; p < PORTS; p++) begin
      if (accept[p]) buf_q[p] <= bus.instruction[p*INSTR_W +: INSTR_W];
    end
  end
endmodule

// File: tb/tb_datapath_router_mc.sv
// Directed bench for datapath_router_mc with PORTS=4, DPS=2 and 32-bit instruction/result.
// Expected values are written out by hand in each scenario task.
module tb_datapath_router_mc;
  localparam int PORTS = 4;
  localparam int DPS   = 2;
  localparam int IW    = 32;
  localparam int RW    = 32;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  datapath_router_mc_if #(.PORTS(PORTS), .DPS(DPS), .INSTR_W(IW), .RESULT_W(RW)) bus ();

  datapath_router_mc #(.PORTS(PORTS), .DPS(DPS), .INSTR_W(IW), .RESULT_W(RW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input int p, input logic [IW-1:0] v);
    bus.instruction[p*IW +: IW] = v;
  endtask

  task automatic set_rdp(input int d, input logic [RW-1:0] v);
    bus.result_dp[d*RW +: RW] = v;
  endtask

  function automatic logic [IW-1:0] idp_of(input int d);
    return bus.instruction_dp[d*IW +: IW];
  endfunction

  task automatic test_reset();
    bus.instruction = '0; bus.start = '0; bus.result_dp = '0; bus.finished_dp = '0;
    #1 resetn = 1'b0;
    #1;
    n_checks++; if (bus.finished !== 4'b1111) begin n_fail++; $display("FAIL reset_finished: got %b want 1111", bus.finished); end
    n_checks++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_checks++; if (bus.overrun !== 4'b0000) begin n_fail++; $display("FAIL reset_overrun: got %b want 0000", bus.overrun); end
    n_checks++; if (bus.instruction_dp !== '0) begin n_fail++; $display("FAIL reset_idp: got %h want 0", bus.instruction_dp); end
    n_checks++; if ({bus.start_dp, bus.busy_dp} !== 4'b0000) begin n_fail++; $display("FAIL reset_dp: got sdp=%b busy=%b want 00/00", bus.start_dp, bus.busy_dp); end
    @(negedge clock) resetn = 1'b1;
    tick();
    n_checks++; if (bus.finished !== 4'b1111 || bus.start_dp !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got fin=%b sdp=%b want 1111/00", bus.finished, bus.start_dp); end
  endtask

  task automatic test_burst();
    logic [RW*PORTS-1:0] exp_res;
    for (int p = 0; p < PORTS; p++) set_instr(p, 32'h1000_0000 + p);
    bus.start = 4'b1111; tick(); bus.start = '0;
    n_checks++; if (bus.finished !== 4'b0000 || bus.start_dp !== 2'b00) begin n_fail++; $display("FAIL burst_accept: got fin=%b sdp=%b want 0000/00", bus.finished, bus.start_dp); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b01 || idp_of(0) !== 32'h1000_0000 || bus.busy_dp !== 2'b01) begin n_fail++; $display("FAIL burst_p0_dp0: got sdp=%b idp0=%h busy=%b want 01/10000000/01", bus.start_dp, idp_of(0), bus.busy_dp); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b10 || idp_of(1) !== 32'h1000_0001 || bus.busy_dp !== 2'b11) begin n_fail++; $display("FAIL burst_p1_dp1: got sdp=%b idp1=%h busy=%b want 10/10000001/11", bus.start_dp, idp_of(1), bus.busy_dp); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b00 || bus.instruction_dp !== {32'h1000_0001, 32'h1000_0000}) begin n_fail++; $display("FAIL burst_hold: got sdp=%b idp=%h want 00/1000000110000000", bus.start_dp, bus.instruction_dp); end
    set_rdp(0, 32'hAAAA_0000); bus.finished_dp = 2'b01; tick(); bus.finished_dp = '0;
    exp_res = {32'h0, 32'h0, 32'h0, 32'hAAAA_0000};
    n_checks++; if (bus.result !== exp_res || bus.finished !== 4'b0001 || bus.busy_dp !== 2'b10 || bus.start_dp !== 2'b00) begin n_fail++; $display("FAIL burst_done0: got res=%h fin=%b busy=%b sdp=%b want %h/0001/10/00", bus.result, bus.finished, bus.busy_dp, bus.start_dp, exp_res); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b01 || idp_of(0) !== 32'h1000_0002) begin n_fail++; $display("FAIL burst_p2_dp0: got sdp=%b idp0=%h want 01/10000002", bus.start_dp, idp_of(0)); end
    set_rdp(1, 32'hAAAA_0001); bus.finished_dp = 2'b10; tick(); bus.finished_dp = '0;
    n_checks++; if (bus.finished !== 4'b0011 || bus.busy_dp !== 2'b01) begin n_fail++; $display("FAIL burst_done1: got fin=%b busy=%b want 0011/01", bus.finished, bus.busy_dp); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b10 || idp_of(1) !== 32'h1000_0003) begin n_fail++; $display("FAIL burst_p3_dp1: got sdp=%b idp1=%h want 10/10000003", bus.start_dp, idp_of(1)); end
    tick();
    set_rdp(0, 32'hAAAA_0002); set_rdp(1, 32'hAAAA_0003); bus.finished_dp = 2'b11; tick(); bus.finished_dp = '0;
    exp_res = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    n_checks++; if (bus.result !== exp_res || bus.finished !== 4'b1111 || bus.busy_dp !== 2'b00) begin n_fail++; $display("FAIL burst_dual_done: got res=%h fin=%b busy=%b want %h/1111/00", bus.result, bus.finished, bus.busy_dp, exp_res); end
  endtask

  task automatic test_single();
    set_instr(2, 32'h0000_00A5); bus.start = 4'b0100; tick(); bus.start = '0;
    n_checks++; if (bus.finished !== 4'b1011 || bus.start_dp !== 2'b00 || bus.busy_dp !== 2'b00) begin n_fail++; $display("FAIL single_latency: got fin=%b sdp=%b busy=%b want 1011/00/00", bus.finished, bus.start_dp, bus.busy_dp); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b01 || idp_of(0) !== 32'h0000_00A5 || bus.busy_dp !== 2'b01) begin n_fail++; $display("FAIL single_dispatch: got sdp=%b idp0=%h busy=%b want 01/000000a5/01", bus.start_dp, idp_of(0), bus.busy_dp); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b00 || bus.busy_dp !== 2'b01) begin n_fail++; $display("FAIL single_pulse: got sdp=%b busy=%b want 00/01", bus.start_dp, bus.busy_dp); end
    set_rdp(0, 32'h0000_1234); bus.finished_dp = 2'b01; tick(); bus.finished_dp = '0;
    n_checks++; if (bus.result[2*RW +: RW] !== 32'h0000_1234 || bus.finished !== 4'b1111 || bus.busy_dp !== 2'b00) begin n_fail++; $display("FAIL single_done: got res2=%h fin=%b busy=%b want 00001234/1111/00", bus.result[2*RW +: RW], bus.finished, bus.busy_dp); end
    tick();
    n_checks++; if (idp_of(0) !== 32'h0000_00A5) begin n_fail++; $display("FAIL single_idp_hold: got %h want 000000a5", idp_of(0)); end
  endtask

  task automatic test_wrap();
    logic [RW*PORTS-1:0] exp_res;
    set_instr(0, 32'h20); set_instr(3, 32'h23); bus.start = 4'b1001; tick(); bus.start = '0;
    tick();
    n_checks++; if (bus.start_dp !== 2'b01 || idp_of(0) !== 32'h23) begin n_fail++; $display("FAIL wrap_p3_first: got sdp=%b idp0=%h want 01/00000023", bus.start_dp, idp_of(0)); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b10 || idp_of(1) !== 32'h20) begin n_fail++; $display("FAIL wrap_p0_next: got sdp=%b idp1=%h want 10/00000020", bus.start_dp, idp_of(1)); end
    tick();
    set_rdp(0, 32'h3333); set_rdp(1, 32'h3000); bus.finished_dp = 2'b11; tick(); bus.finished_dp = '0;
    exp_res = {32'h3333, 32'h1234, 32'hAAAA_0001, 32'h3000};
    n_checks++; if (bus.result !== exp_res || bus.finished !== 4'b1111) begin n_fail++; $display("FAIL wrap_done: got res=%h fin=%b want %h/1111", bus.result, bus.finished, exp_res); end
  endtask

  task automatic test_out_of_order();
    logic [RW*PORTS-1:0] exp_res;
    set_instr(1, 32'h41); set_instr(3, 32'h43); bus.start = 4'b1010; tick(); bus.start = '0;
    tick();
    n_checks++; if (idp_of(0) !== 32'h41 || bus.start_dp !== 2'b01) begin n_fail++; $display("FAIL ooo_p1_dp0: got idp0=%h sdp=%b want 00000041/01", idp_of(0), bus.start_dp); end
    tick();
    n_checks++; if (idp_of(1) !== 32'h43 || bus.start_dp !== 2'b10) begin n_fail++; $display("FAIL ooo_p3_dp1: got idp1=%h sdp=%b want 00000043/10", idp_of(1), bus.start_dp); end
    tick();
    set_rdp(1, 32'hBEEF); bus.finished_dp = 2'b10; tick(); bus.finished_dp = '0;
    exp_res = {32'hBEEF, 32'h1234, 32'hAAAA_0001, 32'h3000};
    n_checks++; if (bus.result !== exp_res || bus.finished !== 4'b1101) begin n_fail++; $display("FAIL ooo_first: got res=%h fin=%b want %h/1101", bus.result, bus.finished, exp_res); end
    tick();
    set_rdp(0, 32'hCAFE); bus.finished_dp = 2'b01; tick(); bus.finished_dp = '0;
    exp_res = {32'hBEEF, 32'h1234, 32'hCAFE, 32'h3000};
    n_checks++; if (bus.result !== exp_res || bus.finished !== 4'b1111) begin n_fail++; $display("FAIL ooo_second: got res=%h fin=%b want %h/1111", bus.result, bus.finished, exp_res); end
  endtask

  task automatic test_overrun_stray();
    logic [RW*PORTS-1:0] exp_res;
    exp_res = {32'hBEEF, 32'h1234, 32'hCAFE, 32'h3000};
    set_instr(1, 32'h11); bus.start = 4'b0010; tick(); bus.start = '0;
    n_checks++; if (bus.overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_clean_accept: got %b want 0000", bus.overrun); end
    set_instr(1, 32'h99); bus.start = 4'b0010; tick(); bus.start = '0;
    n_checks++; if (bus.overrun !== 4'b0010 || idp_of(0) !== 32'h11 || bus.start_dp !== 2'b01) begin n_fail++; $display("FAIL ovr_set: got ovr=%b idp0=%h sdp=%b want 0010/00000011/01", bus.overrun, idp_of(0), bus.start_dp); end
    set_rdp(0, 32'h5555); bus.finished_dp = 2'b01; tick(); bus.finished_dp = '0;
    n_checks++; if (bus.busy_dp !== 2'b01 || bus.finished !== 4'b1101 || bus.result !== exp_res) begin n_fail++; $display("FAIL same_cycle_done: got busy=%b fin=%b res=%h want 01/1101/%h", bus.busy_dp, bus.finished, bus.result, exp_res); end
    set_rdp(1, 32'hDEAD); bus.finished_dp = 2'b10; tick(); bus.finished_dp = '0;
    n_checks++; if (bus.busy_dp !== 2'b01 || bus.finished !== 4'b1101 || bus.result !== exp_res) begin n_fail++; $display("FAIL stray_done: got busy=%b fin=%b res=%h want 01/1101/%h", bus.busy_dp, bus.finished, bus.result, exp_res); end
    set_rdp(0, 32'h7777); bus.finished_dp = 2'b01; tick(); bus.finished_dp = '0;
    exp_res = {32'hBEEF, 32'h1234, 32'h7777, 32'h3000};
    n_checks++; if (bus.result !== exp_res || bus.finished !== 4'b1111 || bus.overrun !== 4'b0010) begin n_fail++; $display("FAIL ovr_sticky: got res=%h fin=%b ovr=%b want %h/1111/0010", bus.result, bus.finished, bus.overrun, exp_res); end
  endtask

  task automatic test_reset_midop();
    set_instr(0, 32'h60); set_instr(1, 32'h61); bus.start = 4'b0011; tick(); bus.start = '0;
    set_instr(2, 32'h62); bus.start = 4'b0100; tick(); bus.start = '0;
    n_checks++; if (idp_of(0) !== 32'h60 || bus.start_dp !== 2'b01) begin n_fail++; $display("FAIL mid_p0_dp0: got idp0=%h sdp=%b want 00000060/01", idp_of(0), bus.start_dp); end
    tick();
    n_checks++; if (idp_of(1) !== 32'h61 || bus.busy_dp !== 2'b11 || bus.finished !== 4'b1000) begin n_fail++; $display("FAIL mid_p1_dp1: got idp1=%h busy=%b fin=%b want 00000061/11/1000", idp_of(1), bus.busy_dp, bus.finished); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b00 || bus.busy_dp !== 2'b11) begin n_fail++; $display("FAIL mid_p2_waits: got sdp=%b busy=%b want 00/11", bus.start_dp, bus.busy_dp); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (bus.finished !== 4'b1111 || bus.result !== '0 || bus.overrun !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_port: got fin=%b res=%h ovr=%b want 1111/0/0000", bus.finished, bus.result, bus.overrun); end
    n_checks++; if (bus.instruction_dp !== '0 || bus.start_dp !== 2'b00 || bus.busy_dp !== 2'b00) begin n_fail++; $display("FAIL mid_reset_dp: got idp=%h sdp=%b busy=%b want 0/00/00", bus.instruction_dp, bus.start_dp, bus.busy_dp); end
    #1 resetn = 1'b1;
    set_rdp(0, 32'hF0F0); set_rdp(1, 32'hF1F1); bus.finished_dp = 2'b11; tick(); bus.finished_dp = '0;
    n_checks++; if (bus.finished !== 4'b1111 || bus.result !== '0 || bus.busy_dp !== 2'b00) begin n_fail++; $display("FAIL late_done: got fin=%b res=%h busy=%b want 1111/0/00", bus.finished, bus.result, bus.busy_dp); end
    tick();
    n_checks++; if (bus.start_dp !== 2'b00) begin n_fail++; $display("FAIL dropped_pending: got sdp=%b want 00", bus.start_dp); end
    set_instr(0, 32'h70); set_instr(3, 32'h73); bus.start = 4'b1001; tick(); bus.start = '0;
    tick();
    n_checks++; if (idp_of(0) !== 32'h70) begin n_fail++; $display("FAIL rr_reset_p0: got idp0=%h want 00000070", idp_of(0)); end
    tick();
    n_checks++; if (idp_of(1) !== 32'h73) begin n_fail++; $display("FAIL rr_reset_p3: got idp1=%h want 00000073", idp_of(1)); end
    tick();
    set_rdp(0, 32'h0707); set_rdp(1, 32'h7373); bus.finished_dp = 2'b11; tick(); bus.finished_dp = '0;
    n_checks++; if (bus.result !== {32'h7373, 32'h0, 32'h0, 32'h0707} || bus.finished !== 4'b1111) begin n_fail++; $display("FAIL post_reset_done: got res=%h fin=%b want 00007373000000000000000000000707/1111", bus.result, bus.finished); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_single();
    test_wrap();
    test_out_of_order();
    test_overrun_stray();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
